// File: rtl/dpdistram_rd_pkg.sv
// rtl/dpdistram_rd_pkg.sv - shared types for the distributed RAM read streamer
package dpdistram_rd_pkg;

  // Command sequencing: RUN issues reads, DRAIN waits for the last word to leave.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with same-cycle write bypass
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty;
  logic             pop;

  // Head selection: stored word first, otherwise the word being written this
  // cycle falls straight through so an empty FIFO adds no latency.
  always_comb begin
    empty    = (count_q == '0);
    rd_valid = !empty || wr_en;
    rd_data  = '0;
    if (!empty) begin
      rd_data = mem_q[rd_ptr_q];
    end else if (wr_en) begin
      rd_data = wr_data;
    end
    pop = rd_valid && rd_en;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  assign count = count_q;

  // Storage array; a bypassed word is also written, harmlessly, since both
  // pointers advance together in that case.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dpdistram_rd_streamer.sv
// rtl/dpdistram_rd_streamer.sv - streams a range of RAM port-B words out as a tvalid/tready stream
module dpdistram_rd_streamer
  import dpdistram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clkb,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  enb,
  output logic                  regceb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic                    zero_done_q, zero_done_d;
  logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [READ_LATENCY-1:0] last_sr_q, last_sr_d;

  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          occupancy;
  logic                    room;
  logic                    issue;
  logic                    issue_last;
  logic                    push;
  logic [DATA_WIDTH:0]     push_word;
  logic [DATA_WIDTH:0]     head_word;
  logic                    head_valid;
  logic                    accept_last;

  // Credit check: every read in flight plus every buffered word already owns a
  // FIFO slot, so a new read is issued only while a slot is still free.
  always_comb begin
    occupancy = {1'b0, fifo_count};
    for (int i = 0; i < READ_LATENCY; i++) begin
      occupancy = occupancy + {{CNT_W{1'b0}}, vld_sr_q[i]};
    end
    room       = (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    issue      = (state_q == ST_RUN) && (rem_q != '0) && room;
    issue_last = issue && (rem_q == (ADDR_WIDTH+1)'(1));
  end

  // Read-return tracker: a read's valid and last flag reach the end of the
  // shift register in the same cycle its data appears on doutb.
  always_comb begin
    vld_sr_d  = {vld_sr_q[READ_LATENCY-2:0], issue};
    last_sr_d = {last_sr_q[READ_LATENCY-2:0], issue_last};
    push      = vld_sr_q[READ_LATENCY-1];
    push_word = {last_sr_q[READ_LATENCY-1], doutb};
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clkb),
    .rst      (rstb),
    .wr_en    (push),
    .wr_data  (push_word),
    .rd_en    (m_tready),
    .rd_data  (head_word),
    .rd_valid (head_valid),
    .count    (fifo_count)
  );

  assign m_tvalid    = head_valid;
  assign m_tdata     = head_word[DATA_WIDTH-1:0];
  assign m_tlast     = head_word[DATA_WIDTH];
  assign accept_last = head_valid && m_tready && head_word[DATA_WIDTH];

  // Command sequencing: latch the command, walk the address range, then wait
  // for the flagged last word to be taken downstream.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    zero_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            addr_d  = start_addr;
            rem_d   = length;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (accept_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = zero_done_q || ((state_q == ST_DRAIN) && accept_last);
  assign addrb  = addr_q;
  assign enb    = issue;
  assign regceb = 1'b1;

  // State, address walker and read tracker registers; reset drops any reads
  // still in flight so their data is never pushed.
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      zero_done_q <= 1'b0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      zero_done_q <= zero_done_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
    end
  end

endmodule

// File: tb/tb_dpdistram_rd_streamer.sv
// tb/tb_dpdistram_rd_streamer.sv - scoreboard bench for dpdistram_rd_streamer
`timescale 1ns/1ps
module tb_dpdistram_rd_streamer;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int FD    = 4;
  localparam int MEM_N = 1 << AW;

  logic          clkb = 1'b0;
  logic          rstb = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, enb, regceb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;

  dpdistram_rd_streamer #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clkb       (clkb),
    .rstb       (rstb),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .addrb      (addrb),
    .enb        (enb),
    .regceb     (regceb),
    .doutb      (doutb),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast)
  );

  always #5 clkb = ~clkb;

  // RAM with two-cycle read latency: address captured, then output register.
  logic [DW-1:0] mem [MEM_N];
  logic [DW-1:0] ram_s1 = '0;
  always @(posedge clkb) begin
    if (enb) ram_s1 <= mem[addrb];
    if (regceb) doutb <= ram_s1;
  end

  int cyc = 0;
  always @(posedge clkb) cyc <= cyc + 1;

  int passes = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          is_last;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  bit            busy_m = 0;
  bit            zpend = 0;
  int            outstanding = 0;

  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            start_cyc = -1;
  int            first_valid_cyc = -1;
  int            done_cnt = 0;

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    start_cyc       = -1;
    first_valid_cyc = -1;
    done_cnt        = 0;
  endtask

  // Scoreboard: each accepted command expands into its address list and word
  // list; every cycle the DUT's reads and stream beats are matched against them.
  always @(negedge clkb) begin
    word_t w;
    bit    done_exp;
    bit    busy_n;
    bit    zpend_n;
    if (rstb) begin
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_enb", 64'(enb), 64'(0));
      check("rst_addrb", 64'(addrb), 64'(0));
      check("rst_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_tlast", 64'(m_tlast), 64'(0));
      check("rst_tdata", 64'(m_tdata), 64'(0));
      exp_q.delete();
      exp_addr_q.delete();
      busy_m      = 0;
      zpend       = 0;
      outstanding = 0;
    end else begin
      check("regceb", 64'(regceb), 64'(1));
      check("busy", 64'(busy), 64'(busy_m));
      done_exp = zpend;
      busy_n   = busy_m;
      zpend_n  = 0;
      if (enb) begin
        log_addr.push_back(addrb);
        if (exp_addr_q.size() == 0) begin
          check("enb_spurious", 64'(enb), 64'(0));
        end else begin
          check("addrb", 64'(addrb), 64'(exp_addr_q.pop_front()));
          outstanding++;
          check("room", 64'(outstanding <= FD), 64'(1));
        end
      end
      if (m_tvalid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("tvalid_spurious", 64'(m_tvalid), 64'(0));
        end else begin
          w = exp_q[0];
          check("m_tdata", 64'(m_tdata), 64'(w.data));
          check("m_tlast", 64'(m_tlast), 64'(w.is_last));
          if (m_tready) begin
            void'(exp_q.pop_front());
            outstanding--;
            log_data.push_back(m_tdata);
            if (w.is_last) begin
              done_exp = 1;
              busy_n   = 0;
            end
          end
        end
      end
      check("done", 64'(done), 64'(done_exp));
      if (done) done_cnt++;
      if (start && !busy_m) begin
        start_cyc = cyc;
        if (length == '0) begin
          zpend_n = 1;
        end else begin
          busy_n = 1;
          for (int i = 0; i < int'(length); i++) begin
            exp_addr_q.push_back(AW'(int'(start_addr) + i));
            exp_q.push_back('{data: mem[AW'(int'(start_addr) + i)], is_last: (i == int'(length) - 1)});
          end
        end
      end
      busy_m = busy_n;
      zpend  = zpend_n;
    end
  end

  int rdy_mode = 0;
  initial forever begin
    @(posedge clkb);
    #1;
    if (rdy_mode == 1) m_tready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clkb);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] l);
    start      = 1'b1;
    start_addr = a;
    length     = l;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || zpend) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", 64'(n < budget), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int exp37[4];
    int n;
    logic [AW-1:0] ra;
    logic [AW:0]   rl;
    int sel;

    for (int i = 0; i < MEM_N; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    exp37 = '{62, 63, 0, 1};

    rstb = 1'b1;
    tick(3);
    rstb = 1'b0;
    tick(2);

    // Basic read of four words with the sink always ready.
    m_tready = 1'b1;
    clear_logs();
    do_start(6'd5, 7'd4);
    wait_idle(100);
    check("d36_n_addr", 64'(log_addr.size()), 64'(4));
    check("d36_n_data", 64'(log_data.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check("d36_addr", 64'(log_addr[i]), 64'(5 + i));
      check("d36_data", 64'(log_data[i]), 64'(32'hC0DE0005 + 32'(i)));
    end
    check("d36_latency", 64'(first_valid_cyc - start_cyc), 64'(3));
    check("d36_done_cnt", 64'(done_cnt), 64'(1));

    // Address wrap at the top of the RAM.
    clear_logs();
    do_start(6'd62, 7'd4);
    wait_idle(100);
    check("d37_n_addr", 64'(log_addr.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check("d37_addr", 64'(log_addr[i]), 64'(exp37[i]));
      check("d37_data", 64'(log_data[i]), 64'(32'hC0DE0000 | 32'(exp37[i])));
    end

    // Zero-length command.
    clear_logs();
    do_start(6'd9, 7'd0);
    check("d39_done", 64'(done), 64'(1));
    check("d39_busy", 64'(busy), 64'(0));
    tick(3);
    check("d39_no_enb", 64'(log_addr.size()), 64'(0));
    check("d39_done_cnt", 64'(done_cnt), 64'(1));

    // Long stall: reads must stop at the buffer capacity.
    m_tready = 1'b0;
    clear_logs();
    do_start(6'd20, 7'd16);
    tick(20);
    check("d38_stall_enb_le4", 64'(log_addr.size() <= 4), 64'(1));
    check("d38_stall_none_out", 64'(log_data.size()), 64'(0));
    m_tready = 1'b1;
    wait_idle(200);
    check("d38_n_data", 64'(log_data.size()), 64'(16));
    for (int i = 0; i < 16; i++) begin
      check("d38_data", 64'(log_data[i]), 64'(32'hC0DE0000 | 32'(20 + i)));
    end
    check("d38_done_cnt", 64'(done_cnt), 64'(1));

    // Second start while running is ignored.
    clear_logs();
    do_start(6'd10, 7'd8);
    tick(2);
    do_start(6'd40, 7'd3);
    wait_idle(200);
    check("d41_n_addr", 64'(log_addr.size()), 64'(8));
    check("d41_last_addr", 64'(log_addr[7]), 64'(17));
    check("d41_n_data", 64'(log_data.size()), 64'(8));
    check("d41_done_cnt", 64'(done_cnt), 64'(1));

    // Reset in the middle of a command, then a fresh short command.
    clear_logs();
    do_start(6'd20, 7'd10);
    n = 0;
    while (log_data.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check("d40_reach3", 64'(n < 50), 64'(1));
    rstb = 1'b1;
    tick(2);
    rstb = 1'b0;
    tick(2);
    check("d40_post_busy", 64'(busy), 64'(0));
    check("d40_post_tvalid", 64'(m_tvalid), 64'(0));
    check("d40_post_enb", 64'(enb), 64'(0));
    clear_logs();
    do_start(6'd0, 7'd2);
    wait_idle(100);
    tick(5);
    check("d40_n_data", 64'(log_data.size()), 64'(2));
    check("d40_data0", 64'(log_data[0]), 64'(32'hC0DE0000));
    check("d40_data1", 64'(log_data[1]), 64'(32'hC0DE0001));
    check("d40_done_cnt", 64'(done_cnt), 64'(1));

    // Randomized commands with random RAM contents and random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      wait_idle(2000);
      for (int i = 0; i < MEM_N; i++) mem[i] = $urandom;
      ra  = AW'($urandom_range(0, MEM_N - 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) rl = '0;
      else if (sel == 1) rl = (AW+1)'(MEM_N);
      else rl = (AW+1)'($urandom_range(1, 20));
      do_start(ra, rl);
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(0, 5));
        do_start(AW'($urandom_range(0, MEM_N - 1)), (AW+1)'($urandom_range(0, 8)));
      end
    end
    rdy_mode = 0;
    m_tready = 1'b1;
    wait_idle(2000);
    tick(5);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_busy", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
